i2c_slave_reg_ctrl: RTL and testbench
=====================================

// Module: i2c_slave_reg_ctrl
// PURPOSE
//  Register-access controller between the I2C slave byte PHY and the 32x8 register RAM.
//  - Decodes the address byte and the register-pointer byte, and handles auto-increment.
//  - Drives the RAM write port. Prefetches read bytes for transmission.
//  - The RAM read port updates only on write-enabled cycles. Every read fetch is therefore
//    a write of 0x00 to scratch address 31, with the read address set to the pointer.
// PARAMETERS
//  SLAVE_ADDR    7'h50  7-bit bus address this slave answers to
//  AW            5      RAM address width
//  SCRATCH_ADDR  31     RAM location reserved as the dummy write target for read fetches
//  LAST_REG      30     highest host-visible register; the pointer wraps from here to 0
// PORTS
//  clk       in   1   system clock; all logic on its rising edge
//  rst_n     in   1   asynchronous, active-low reset
//  bus_start in   1   1-cycle pulse: START or repeated START detected by PHY
//  bus_stop  in   1   1-cycle pulse: STOP detected by PHY
//  rx_valid  in   1   1-cycle pulse: rx_byte holds a complete received byte
//  rx_byte   in   8   received byte (first byte after START = {addr[6:0], R/W})
//  ack_valid out  1   1-cycle pulse, one cycle after rx_valid
//  ack       out  1   ACK decision for that byte (1 = pull SDA low)
//  tx_req    in   1   1-cycle pulse: PHY consumed tx_data and the master ACKed
//  tx_nack   in   1   1-cycle pulse: master NACKed the last transmitted byte
//  tx_valid  out  1   tx_data is valid; held until tx_req, tx_nack, start or stop
//  tx_data   out  8   next byte to transmit
//  ram_wadd  out  AW  RAM write address
//  ram_din   out  8   RAM write data
//  ram_w     out  1   RAM write enable (also strobes the RAM read port)
//  ram_radd  out  AW  RAM read address
//  ram_dout  in   8   RAM read data (registered in the RAM)
// BEHAVIOUR
//  Reset: all outputs are 0, ptr=0, state=IDLE. Takes effect immediately, also mid-transfer
//    (ram_w drops asynchronously). The RAM contents are not affected.
//  All outputs are registered. ram_w is high for exactly 1 cycle per write or fetch.
//  FSM states: IDLE, ADDR, PTR, WDATA, RFETCH, RWAIT, RDATA, IGNORE.
//   - Any state, bus_stop -> IDLE.
//   - Any state, bus_start -> ADDR. bus_start wins over bus_stop and rx_valid in the same
//     cycle; the byte is dropped. ptr is kept across a repeated START.
//   - ADDR, on rx_valid:
//       rx_byte[7:1]==SLAVE_ADDR: ack=1; R/W=0 -> PTR, R/W=1 -> RFETCH.
//       Otherwise: ack=0 -> IGNORE.
//   - PTR, on rx_valid: ptr <= rx_byte[AW-1:0]; a value above LAST_REG loads 0; ack=1
//     -> WDATA.
//   - WDATA, on rx_valid: ram_w=1, ram_wadd=ptr, ram_din=rx_byte; ack=1; ptr++ with wrap.
//     Write issued at T+1 (T = rx_valid cycle).
//   - RFETCH (trigger cycle T): T+1 ram_w=1, ram_wadd=SCRATCH_ADDR, ram_din=0,
//     ram_radd=ptr -> RWAIT. T+2 ram_dout valid. T+3 tx_data<=ram_dout, tx_valid=1,
//     ptr++ with wrap -> RDATA.
//   - RDATA: tx_req -> tx_valid=0, re-enter RFETCH. tx_nack -> tx_valid=0 -> IGNORE.
//   - IGNORE: ack=0 for every rx_valid; no RAM activity.
//  ack_valid pulses for every rx_valid outside IDLE; ack=0 in IDLE/IGNORE.
//  In IDLE, rx_valid is ignored with no ack_valid.
//  ram_wadd never equals SCRATCH_ADDR on a host write; host data never reaches address 31.
//  tx_req or tx_nack while tx_valid=0 (fetch in flight): ignored. The PHY must allow
//    3 clk latency (clk >> SCL).
// STRUCTURE
//  Package i2c_slave_pkg: state enum, SLAVE_ADDR default, AW, SCRATCH_ADDR, LAST_REG.
//  Sub-module i2c_reg_ptr: pointer register with load (clamp) and wrap increment.
//  Everything else (FSM, output registers) lives in this module.
// TESTING
//  1. Write burst: start, A0, 05, 3C, 7E, stop
//     -> 4 ack=1; ram_w writes 3C@5 then 7E@6; ptr=7; IDLE.
//  2. Random read: start, A0, 05, start, A1
//     -> fetch wadd=31 radd=5; tx_data=3C at T+3; tx_req -> 7E; tx_nack -> no further ram_w.
//  3. Foreign address: start, A2, 11, 22, stop
//     -> ack_valid with ack=0 on all bytes; ram_w never high.
//  4. Wrap/clamp:
//     - ptr byte 1E, write 01, 02 -> writes at 30 then 0.
//     - ptr byte 1F -> ptr=0.
//     - read from 30 -> next fetch radd=0.
//  5. Precedence: bus_start coincident with rx_valid in WDATA
//     -> no write; state ADDR; ptr unchanged.
//  6. Reset mid-write: rst_n low while ram_w=1
//     -> ram_w=0 at once, IDLE, ptr=0; a following full write transfer succeeds.

Source files
------------

// File: rtl/i2c_slave_reg_ctrl_pkg.sv
// Shared definitions for the I2C slave register controller.
//   state_t            : controller FSM states
//   SLAVE_ADDR_DEFAULT : default 7-bit bus address
//   AW                 : register RAM address width
//   SCRATCH_ADDR       : RAM location used as the dummy write target of read fetches
//   LAST_REG           : highest host-visible register (pointer wraps to 0 after it)
package i2c_slave_pkg;

   localparam logic [6:0]  SLAVE_ADDR_DEFAULT = 7'h50;
   localparam int unsigned AW                 = 5;
   localparam int unsigned SCRATCH_ADDR       = 31;
   localparam int unsigned LAST_REG           = 30;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      PTR,
      WDATA,
      RFETCH,
      RWAIT,
      RDATA,
      IGNORE
   } state_t;

endpackage

// File: rtl/i2c_slave_reg_ctrl_if.sv
// Byte-level handshake between the I2C slave PHY and the register controller.
//   bus_start/bus_stop : 1-cycle START/STOP pulses from the PHY
//   rx_valid/rx_byte   : received byte strobe and data
//   ack_valid/ack      : ACK decision for the last received byte
//   tx_req/tx_nack     : master ACKed / NACKed the last transmitted byte
//   tx_valid/tx_data   : next byte to transmit
// Modports: slave = controller side, master = PHY side.
interface i2c_slave_reg_ctrl_if;

   logic       bus_start;
   logic       bus_stop;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       ack_valid;
   logic       ack;
   logic       tx_req;
   logic       tx_nack;
   logic       tx_valid;
   logic [7:0] tx_data;

   modport slave (
      input  bus_start, bus_stop, rx_valid, rx_byte, tx_req, tx_nack,
      output ack_valid, ack, tx_valid, tx_data
   );

   modport master (
      output bus_start, bus_stop, rx_valid, rx_byte, tx_req, tx_nack,
      input  ack_valid, ack, tx_valid, tx_data
   );

endinterface

// File: rtl/i2c_slave_reg_ctrl_ptr.sv
// Register pointer for the I2C slave controller.
//   clk, rst_n : clock, asynchronous active-low reset (pointer clears to 0)
//   load       : load load_val; values above LAST_REG load 0
//   load_val   : new pointer value
//   inc        : advance by one, wrapping from LAST_REG to 0 (load has priority)
//   ptr        : current pointer
module i2c_reg_ptr
   import i2c_slave_pkg::*;
#(
   parameter int unsigned AW       = i2c_slave_pkg::AW,
   parameter int unsigned LAST_REG = i2c_slave_pkg::LAST_REG
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [AW-1:0] load_val,
   input  logic          inc,
   output logic [AW-1:0] ptr
);

   localparam logic [AW-1:0] LAST = AW'(LAST_REG);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (load) begin
         ptr <= (load_val > LAST) ? '0 : load_val;
      end else if (inc) begin
         ptr <= (ptr == LAST) ? '0 : ptr + AW'(1);
      end
   end

endmodule

// File: rtl/i2c_slave_reg_ctrl.sv
// Register-access controller between the I2C slave byte PHY and a 32x8 register RAM.
// Decodes the address and register-pointer bytes, writes host data with pointer
// auto-increment, and prefetches read bytes for transmission.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus             : PHY handshake (slave modport)
//   ram_wadd/ram_din/ram_w : RAM write port; ram_w also strobes the RAM read port
//   ram_radd        : RAM read address
//   ram_dout        : RAM read data (registered inside the RAM)
module i2c_slave_reg_ctrl
   import i2c_slave_pkg::*;
#(
   parameter logic [6:0]  SLAVE_ADDR   = i2c_slave_pkg::SLAVE_ADDR_DEFAULT,
   parameter int unsigned AW           = i2c_slave_pkg::AW,
   parameter int unsigned SCRATCH_ADDR = i2c_slave_pkg::SCRATCH_ADDR,
   parameter int unsigned LAST_REG     = i2c_slave_pkg::LAST_REG
) (
   input  logic                 clk,
   input  logic                 rst_n,
   i2c_slave_reg_ctrl_if.slave  bus,
   output logic [AW-1:0]        ram_wadd,
   output logic [7:0]           ram_din,
   output logic                 ram_w,
   output logic [AW-1:0]        ram_radd,
   input  logic [7:0]           ram_dout
);

   state_t        state;
   logic          ack_valid_q;
   logic          ack_q;
   logic          tx_valid_q;
   logic [7:0]    tx_data_q;
   logic [AW-1:0] ptr;
   logic          active;
   logic          ptr_load;
   logic          ptr_inc;

   assign bus.ack_valid = ack_valid_q;
   assign bus.ack       = ack_q;
   assign bus.tx_valid  = tx_valid_q;
   assign bus.tx_data   = tx_data_q;

   // Pointer strobes mirror the FSM's own decisions; START/STOP suppress them.
   always_comb begin
      active   = !bus.bus_start && !bus.bus_stop;
      ptr_load = active && (state == PTR) && bus.rx_valid;
      ptr_inc  = active && (((state == WDATA) && bus.rx_valid) ||
                            ((state == RDATA) && !tx_valid_q));
   end

   i2c_reg_ptr #(
      .AW       (AW),
      .LAST_REG (LAST_REG)
   ) u_ptr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ptr_load),
      .load_val (bus.rx_byte[AW-1:0]),
      .inc      (ptr_inc),
      .ptr      (ptr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ack_valid_q <= 1'b0;
         ack_q       <= 1'b0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= '0;
         ram_w       <= 1'b0;
         ram_wadd    <= '0;
         ram_din     <= '0;
         ram_radd    <= '0;
      end else begin
         ack_valid_q <= 1'b0;
         ram_w       <= 1'b0;
         if (bus.bus_start) begin
            state      <= ADDR;
            tx_valid_q <= 1'b0;
         end else if (bus.bus_stop) begin
            state      <= IDLE;
            tx_valid_q <= 1'b0;
         end else begin
            // Every byte outside IDLE is answered; states that accept it override ack.
            if (bus.rx_valid && (state != IDLE)) begin
               ack_valid_q <= 1'b1;
               ack_q       <= 1'b0;
            end
            case (state)
               ADDR: begin
                  if (bus.rx_valid) begin
                     if (bus.rx_byte[7:1] == SLAVE_ADDR) begin
                        ack_q <= 1'b1;
                        state <= bus.rx_byte[0] ? RFETCH : PTR;
                     end else begin
                        state <= IGNORE;
                     end
                  end
               end
               PTR: begin
                  if (bus.rx_valid) begin
                     ack_q <= 1'b1;
                     state <= WDATA;
                  end
               end
               WDATA: begin
                  if (bus.rx_valid) begin
                     ack_q    <= 1'b1;
                     ram_w    <= 1'b1;
                     ram_wadd <= ptr;
                     ram_din  <= bus.rx_byte;
                  end
               end
               RFETCH: begin
                  // Dummy scratch write clocks the RAM read port at ptr.
                  ram_w    <= 1'b1;
                  ram_wadd <= AW'(SCRATCH_ADDR);
                  ram_din  <= '0;
                  ram_radd <= ptr;
                  state    <= RWAIT;
               end
               RWAIT: begin
                  state <= RDATA;
               end
               RDATA: begin
                  // Entered with tx_valid low: first cycle captures ram_dout, then the
                  // byte is held until the master ACKs or NACKs it.
                  if (!tx_valid_q) begin
                     tx_data_q  <= ram_dout;
                     tx_valid_q <= 1'b1;
                  end else if (bus.tx_req) begin
                     tx_valid_q <= 1'b0;
                     state      <= RFETCH;
                  end else if (bus.tx_nack) begin
                     tx_valid_q <= 1'b0;
                     state      <= IGNORE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_reg_ctrl.sv
// Self-checking bench for i2c_slave_reg_ctrl: directed transfers plus randomized
// write/read/foreign transactions, checked against a transaction-level model of the
// register file and pointer.
module tb_i2c_slave_reg_ctrl;

   localparam logic [6:0] SA = 7'h50;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   i2c_slave_reg_ctrl_if phy();

   logic [4:0] ram_wadd;
   logic [4:0] ram_radd;
   logic [7:0] ram_din;
   logic       ram_w;
   logic [7:0] ram_dout = 8'h00;

   i2c_slave_reg_ctrl #(
      .SLAVE_ADDR   (SA),
      .AW           (5),
      .SCRATCH_ADDR (31),
      .LAST_REG     (30)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (phy),
      .ram_wadd (ram_wadd),
      .ram_din  (ram_din),
      .ram_w    (ram_w),
      .ram_radd (ram_radd),
      .ram_dout (ram_dout)
   );

   // Register RAM whose read port only updates on write-enabled cycles.
   logic [7:0] ram [32] = '{default: 8'h00};
   always @(posedge clk) begin
      if (ram_w === 1'b1) begin
         ram[ram_wadd] <= ram_din;
         ram_dout      <= ram[ram_radd];
      end
   end

   int wr_cnt = 0;
   always @(posedge clk) if (ram_w === 1'b1) wr_cnt <= wr_cnt + 1;

   // Reference model: register contents, pointer, and transaction progress.
   logic [7:0] ref_mem [0:30];
   int         ref_ptr;
   bit         in_txn;
   bit         sel;
   bit         rd;
   int         byte_idx;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic int clamp_ptr(input logic [7:0] b);
      int p;
      p = int'(b) % 32;
      return (p > 30) ? 0 : p;
   endfunction

   function automatic int next_ptr(input int p);
      return (p == 30) ? 0 : p + 1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_start();
      phy.bus_start = 1'b1;
      tick();
      phy.bus_start = 1'b0;
      in_txn = 1'b1; byte_idx = 0; sel = 1'b0; rd = 1'b0;
   endtask

   task automatic bus_stop();
      phy.bus_stop = 1'b1;
      tick();
      phy.bus_stop = 1'b0;
      in_txn = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit exp_av, exp_ack, exp_w;
      int exp_a;
      exp_av = in_txn; exp_ack = 1'b0; exp_w = 1'b0; exp_a = 0;
      if (in_txn) begin
         if (byte_idx == 0) begin
            sel = (b[7:1] == SA); rd = b[0]; exp_ack = sel;
         end else if (sel && !rd) begin
            exp_ack = 1'b1;
            if (byte_idx == 1) begin
               ref_ptr = clamp_ptr(b);
            end else begin
               exp_w = 1'b1; exp_a = ref_ptr;
               ref_mem[ref_ptr] = b;
               ref_ptr = next_ptr(ref_ptr);
            end
         end
         byte_idx++;
      end
      phy.rx_byte = b; phy.rx_valid = 1'b1;
      tick();
      phy.rx_valid = 1'b0;
      n_checks++;
      if (phy.ack_valid !== exp_av || (exp_av && phy.ack !== exp_ack)) begin
         n_fail++;
         $display("FAIL ack byte=%h: ack_valid=%b ack=%b, required ack_valid=%b ack=%b",
                  b, phy.ack_valid, phy.ack, exp_av, exp_ack);
      end
      n_checks++;
      if (ram_w !== exp_w || (exp_w && (ram_wadd !== 5'(exp_a) || ram_din !== b))) begin
         n_fail++;
         $display("FAIL write byte=%h: ram_w=%b wadd=%0d din=%h, required ram_w=%b wadd=%0d din=%h",
                  b, ram_w, ram_wadd, ram_din, exp_w, exp_a, b);
      end
   endtask

   // Called right after the edge that puts the controller into a fetch.
   task automatic fetch_expect();
      int a;
      a = ref_ptr;
      tick();
      n_checks++;
      if (ram_w !== 1'b1 || ram_wadd !== 5'd31 || ram_din !== 8'h00 || ram_radd !== 5'(a)) begin
         n_fail++;
         $display("FAIL fetch: ram_w=%b wadd=%0d din=%h radd=%0d, required 1 31 00 %0d",
                  ram_w, ram_wadd, ram_din, ram_radd, a);
      end
      tick();
      n_checks++;
      if (phy.tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL tx_early: tx_valid=%b, required 0", phy.tx_valid);
      end
      tick();
      n_checks++;
      if (phy.tx_valid !== 1'b1 || phy.tx_data !== ref_mem[a]) begin
         n_fail++;
         $display("FAIL tx_data reg %0d: tx_valid=%b tx_data=%h, required 1 %h",
                  a, phy.tx_valid, phy.tx_data, ref_mem[a]);
      end
      ref_ptr = next_ptr(a);
   endtask

   task automatic rd_ack();
      phy.tx_req = 1'b1;
      tick();
      phy.tx_req = 1'b0;
      n_checks++;
      if (phy.tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL tx_req_drop: tx_valid=%b, required 0", phy.tx_valid);
      end
      fetch_expect();
   endtask

   task automatic rd_nack();
      int w0;
      phy.tx_nack = 1'b1;
      tick();
      phy.tx_nack = 1'b0;
      sel = 1'b0;
      n_checks++;
      if (phy.tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL tx_nack_drop: tx_valid=%b, required 0", phy.tx_valid);
      end
      w0 = wr_cnt;
      repeat (4) tick();
      n_checks++;
      if (wr_cnt !== w0) begin
         n_fail++;
         $display("FAIL nack_quiet: ram writes=%0d, required 0", wr_cnt - w0);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (phy.ack_valid !== 1'b0 || phy.ack !== 1'b0 || phy.tx_valid !== 1'b0 ||
          phy.tx_data !== 8'h00 || ram_w !== 1'b0 || ram_wadd !== 5'd0 ||
          ram_din !== 8'h00 || ram_radd !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: av=%b ack=%b tv=%b td=%h w=%b wa=%0d din=%h ra=%0d, required all 0",
                  phy.ack_valid, phy.ack, phy.tx_valid, phy.tx_data, ram_w, ram_wadd, ram_din, ram_radd);
      end
      rst_n = 1'b1;
      ref_ptr = 0; in_txn = 1'b0;
      tick();
   endtask

   task automatic test_write_burst();
      bus_start();
      send_byte(8'hA0); send_byte(8'h05); send_byte(8'h3C); send_byte(8'h7E);
      bus_stop();
      send_byte(8'h11);                      // IDLE: no ack_valid expected
      bus_start();
      send_byte(8'hA1);                      // reads from ptr=7
      fetch_expect();
      rd_nack();
      bus_stop();
   endtask

   task automatic test_random_read();
      bus_start();
      send_byte(8'hA0); send_byte(8'h05);
      bus_start();
      send_byte(8'hA1);
      fetch_expect();                        // 3C from register 5
      rd_ack();                              // 7E from register 6
      rd_nack();
      bus_stop();
   endtask

   task automatic test_foreign();
      int w0;
      w0 = wr_cnt;
      bus_start();
      send_byte(8'hA2); send_byte(8'h11); send_byte(8'h22);
      bus_stop();
      n_checks++;
      if (wr_cnt !== w0) begin
         n_fail++;
         $display("FAIL foreign_no_write: ram writes=%0d, required 0", wr_cnt - w0);
      end
   endtask

   task automatic test_wrap();
      bus_start();
      send_byte(8'hA0); send_byte(8'h1E); send_byte(8'h01); send_byte(8'h02);
      bus_stop();
      bus_start();
      send_byte(8'hA0); send_byte(8'h1F); send_byte(8'hAA);
      bus_stop();
      bus_start();
      send_byte(8'hA0); send_byte(8'h1E);
      bus_start();
      send_byte(8'hA1);
      fetch_expect();
      rd_ack();
      rd_nack();
      bus_stop();
   endtask

   task automatic test_precedence();
      bus_start();
      send_byte(8'hA0); send_byte(8'h08);
      phy.bus_start = 1'b1; phy.rx_byte = 8'h55; phy.rx_valid = 1'b1;
      tick();
      phy.bus_start = 1'b0; phy.rx_valid = 1'b0;
      in_txn = 1'b1; byte_idx = 0; sel = 1'b0; rd = 1'b0;
      n_checks++;
      if (phy.ack_valid !== 1'b0 || ram_w !== 1'b0) begin
         n_fail++;
         $display("FAIL start_precedence: ack_valid=%b ram_w=%b, required 0 0", phy.ack_valid, ram_w);
      end
      send_byte(8'hA1);                      // now in ADDR; ptr still 8
      fetch_expect();
      rd_nack();
      bus_stop();
   endtask

   task automatic test_reset_mid_write();
      bus_start();
      send_byte(8'hA0); send_byte(8'h03);
      phy.rx_byte = 8'h99; phy.rx_valid = 1'b1;
      tick();
      phy.rx_valid = 1'b0;
      n_checks++;
      if (ram_w !== 1'b1 || ram_wadd !== 5'd3) begin
         n_fail++;
         $display("FAIL pre_reset_write: ram_w=%b wadd=%0d, required 1 3", ram_w, ram_wadd);
      end
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (ram_w !== 1'b0 || phy.ack_valid !== 1'b0 || phy.tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: ram_w=%b ack_valid=%b tx_valid=%b, required 0 0 0",
                  ram_w, phy.ack_valid, phy.tx_valid);
      end
      ref_ptr = 0; in_txn = 1'b0;        // aborted byte never reaches the RAM
      tick();
      rst_n = 1'b1;
      tick();
      bus_start();
      send_byte(8'hA1);                      // ptr cleared to 0
      fetch_expect();
      rd_nack();
      bus_stop();
      bus_start();
      send_byte(8'hA0); send_byte(8'h03); send_byte(8'h77);
      bus_stop();
      bus_start();
      send_byte(8'hA0); send_byte(8'h03);
      bus_start();
      send_byte(8'hA1);
      fetch_expect();
      rd_nack();
      bus_stop();
   endtask

   task automatic test_random();
      int kind, n;
      logic [6:0] fa;
      for (int t = 0; t < 30; t++) begin
         kind = $urandom_range(0, 2);
         if (kind == 0) begin
            bus_start();
            send_byte(8'hA0);
            send_byte(8'($urandom_range(0, 255)));
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)));
            bus_stop();
         end else if (kind == 1) begin
            bus_start();
            send_byte(8'hA0);
            send_byte(8'($urandom_range(0, 255)));
            bus_start();
            send_byte(8'hA1);
            fetch_expect();
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) rd_ack();
            rd_nack();
            bus_stop();
         end else begin
            fa = 7'($urandom_range(0, 127));
            if (fa == SA) fa = fa + 7'd1;
            bus_start();
            send_byte({fa, 1'($urandom_range(0, 1))});
            n = $urandom_range(1, 2);
            for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)));
            bus_stop();
         end
         repeat (2) tick();
      end
   endtask

   initial begin
      phy.bus_start = 1'b0; phy.bus_stop = 1'b0; phy.rx_valid = 1'b0;
      phy.rx_byte = 8'h00; phy.tx_req = 1'b0; phy.tx_nack = 1'b0;
      for (int i = 0; i <= 30; i++) ref_mem[i] = 8'h00;
      ref_ptr = 0; in_txn = 1'b0; sel = 1'b0; rd = 1'b0; byte_idx = 0;
      test_reset();
      test_write_burst();
      test_random_read();
      test_foreign();
      test_wrap();
      test_precedence();
      test_reset_mid_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
